lcd_write_engine: RTL and testbench
===================================

LCD_WRITE_ENGINE -- requirements
Module: lcd_write_engine

Interface
REQ-001 Parameter PWRUP_CYC, 750000, power-on wait before the first command (15 ms at 50 MHz).
REQ-002 Parameter EPW_CYC, 12, LCD_E high width in clocks.
REQ-003 Parameter CMD_CYC, 2000, post-E settle for normal commands and characters.
REQ-004 Parameter CLR_CYC, 82000, post-E settle for the clear command 0x01.
REQ-005 clkLCD  input  1  single clock; all state changes on its rising edge.
REQ-006 resetLCD_n  input  1  reset, asynchronous assert, active-low.
REQ-007 writeStart  input  1  one-cycle request to write the character on data.
REQ-008 data  input  8  ASCII character, sampled in the writeStart cycle.
REQ-009 clrLCD  input  1  clear request, rising-edge sensitive.
REQ-010 initDone  output  1  high when ready to accept writeStart; low during init or clear.
REQ-011 writeDone  output  1  one-cycle pulse when the character write completes.
REQ-012 LCD_RS, LCD_RW, LCD_E  output  1 each  HD44780 register select, read/write (tied 0), enable.
REQ-013 LCD_DB  output  8  HD44780 data bus.

Function
REQ-014 States: PWRUP, INIT_CMD, READY, SETUP, EHIGH, HOLD, WAIT, DONE; one shared 20-bit down-counter.
REQ-015 PWRUP waits PWRUP_CYC clocks, then issues the init list 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 (RS=0) in order.
REQ-016 Every bus transfer: SETUP 1 clock (RS/DB valid, E=0), EHIGH EPW_CYC clocks (E=1), HOLD 1 clock (E=0, DB held), WAIT CMD_CYC clocks, or CLR_CYC clocks for 0x01.
REQ-017 After the last init command's WAIT, enter READY and set initDone=1 on that same transition.
REQ-018 In READY, writeStart=1 latches data, clears initDone and drives RS=1 for the transfer.
REQ-019 writeDone is high for exactly one clock, EPW_CYC+CMD_CYC+3 clocks after the writeStart sampling edge; initDone returns high in that same cycle.
REQ-020 writeStart when initDone=0 is ignored; no writeDone is produced.
REQ-021 A clrLCD rising edge in READY clears initDone next clock and issues 0x01 with CLR_CYC wait; also resets the column counter to 0; initDone returns 1 afterwards without writeDone.
REQ-022 clrLCD held high across the clear's completion does not start a second clear; a rising edge while busy is discarded.
REQ-023 writeStart and a clrLCD rising edge in the same READY cycle: clear wins, the character is dropped.
REQ-024 A 6-bit column counter increments per completed character, range 0..31, wrapping 31->0.
REQ-025 LCD_RW is constant 0; LCD_DB holds its last value outside transfers.

Reset
REQ-026 resetLCD_n low forces immediately: state PWRUP, counter=PWRUP_CYC, LCD_E=0, LCD_RS=0, LCD_DB=0x00, initDone=0, writeDone=0, column=0.
REQ-027 Reset mid-transfer aborts it with no writeDone; on release the full power-up init repeats.

Configuration
REQ-028 Macro LCD_AUTOWRAP_EN defined: before a character when column is 16, issue command 0xC0 (RS=0, CMD_CYC wait); when column is 0 after a wrap, issue 0x80; the character follows; writeDone latency increases by EPW_CYC+CMD_CYC+3.
REQ-029 LCD_AUTOWRAP_EN undefined: no address commands; the column counter still runs, and latency is per REQ-019.

Verification (PWRUP_CYC=20, EPW_CYC=2, CMD_CYC=4, CLR_CYC=10)
REQ-030 Release reset -> six E pulses with DB 0x38,0x38,0x38,0x0C,0x01,0x06, RS=0, then initDone=1.
REQ-031 writeStart with data=0x41 in READY -> RS=1, DB=0x41, E high 2 clocks, writeDone pulse exactly 9 clocks later.
REQ-032 clrLCD held high 30 clocks -> exactly one 0x01 transfer, initDone low for 1+2+1+10+1 clocks, no writeDone.
REQ-033 writeStart and clrLCD rising edge in the same cycle -> only 0x01 on the bus, no writeDone.
REQ-034 LCD_AUTOWRAP_EN, 17 writes of 0x30 -> 0xC0 command before the 17th character; reset asserted during its EHIGH -> E=0 and initDone=0 at once, full init on release.

Source files
------------

// File: rtl/lcd_write_engine_if.sv
// rtl/lcd_write_engine_if.sv - host-side request/status interface of lcd_write_engine
interface lcd_write_engine_if;
  logic       writeStart;
  logic [7:0] data;
  logic       clrLCD;
  logic       initDone;
  logic       writeDone;

  modport master (output writeStart, data, clrLCD, input initDone, writeDone);
  modport slave  (input writeStart, data, clrLCD, output initDone, writeDone);
endinterface

// File: rtl/lcd_write_engine.sv
// rtl/lcd_write_engine.sv - HD44780 8-bit init/clear/character write engine
// Optional line wrap at column 16/32 enabled by defining LCD_AUTOWRAP_EN.
module lcd_write_engine #(
  parameter int PWRUP_CYC = 750000,
  parameter int EPW_CYC   = 12,
  parameter int CMD_CYC   = 2000,
  parameter int CLR_CYC   = 82000
) (
  input  logic              clkLCD,
  input  logic              resetLCD_n,
  lcd_write_engine_if.slave host,
  output logic              LCD_RS,
  output logic              LCD_RW,
  output logic              LCD_E,
  output logic [7:0]        LCD_DB
);
  typedef enum logic [2:0] {PWRUP, INIT_CMD, READY, SETUP, EHIGH, HOLD, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OP_INIT, OP_CHAR, OP_CLR, OP_ADDR} op_t;

  state_t      state, next_state;
  op_t         op;
  logic [19:0] cnt;
  logic [2:0]  init_idx;
  logic [5:0]  column;
  logic [7:0]  char_q;
  logic        clr_q, clr_edge, cnt_done, last_init, write_done;
`ifdef LCD_AUTOWRAP_EN
  logic        wrapped;
`endif

  assign clr_edge       = host.clrLCD & ~clr_q;
  assign cnt_done       = (cnt == 20'd1);
  assign last_init      = (init_idx == 3'd5);
  assign LCD_RW         = 1'b0;
  assign host.writeDone = write_done;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd3:    init_cmd = 8'h0C;
      3'd4:    init_cmd = 8'h01;
      3'd5:    init_cmd = 8'h06;
      default: init_cmd = 8'h38;
    endcase
  endfunction

  always_ff @(posedge clkLCD or negedge resetLCD_n) begin
    if (!resetLCD_n) state <= PWRUP;
    else             state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      PWRUP:    if (cnt_done) next_state = INIT_CMD;
      INIT_CMD: next_state = SETUP;
      READY:    if (clr_edge || host.writeStart) next_state = SETUP;
      SETUP:    next_state = EHIGH;
      EHIGH:    if (cnt_done) next_state = HOLD;
      HOLD:     next_state = WAIT;
      WAIT: begin
        if (cnt_done) begin
          case (op)
            OP_INIT: next_state = last_init ? READY : INIT_CMD;
            OP_ADDR: next_state = INIT_CMD;
            default: next_state = DONE;
          endcase
        end
      end
      DONE:     next_state = READY;
      default:  next_state = PWRUP;
    endcase
  end

  always_comb begin
    LCD_E         = 1'b0;
    host.initDone = 1'b0;
    case (state)
      EHIGH:   LCD_E = 1'b1;
      READY:   host.initDone = 1'b1;
      default: ;
    endcase
  end

  // Datapath: bus registers, shared down-counter, init index, column tracking.
  always_ff @(posedge clkLCD or negedge resetLCD_n) begin
    if (!resetLCD_n) begin
      cnt        <= 20'(PWRUP_CYC);
      op         <= OP_INIT;
      init_idx   <= 3'd0;
      column     <= 6'd0;
      char_q     <= 8'h00;
      clr_q      <= 1'b0;
      write_done <= 1'b0;
      LCD_RS     <= 1'b0;
      LCD_DB     <= 8'h00;
`ifdef LCD_AUTOWRAP_EN
      wrapped    <= 1'b0;
`endif
    end else begin
      clr_q      <= host.clrLCD;
      write_done <= 1'b0;
      case (state)
        PWRUP: cnt <= cnt - 20'd1;
        INIT_CMD: begin
          // Also used to launch the character held back behind an address command.
          if (op == OP_ADDR) begin
            op     <= OP_CHAR;
            LCD_RS <= 1'b1;
            LCD_DB <= char_q;
          end else begin
            LCD_RS <= 1'b0;
            LCD_DB <= init_cmd(init_idx);
          end
        end
        READY: begin
          if (clr_edge) begin
            op     <= OP_CLR;
            LCD_RS <= 1'b0;
            LCD_DB <= 8'h01;
            column <= 6'd0;
`ifdef LCD_AUTOWRAP_EN
            wrapped <= 1'b0;
`endif
          end else if (host.writeStart) begin
            char_q <= host.data;
            op     <= OP_CHAR;
            LCD_RS <= 1'b1;
            LCD_DB <= host.data;
`ifdef LCD_AUTOWRAP_EN
            if (column == 6'd16 || (column == 6'd0 && wrapped)) begin
              op     <= OP_ADDR;
              LCD_RS <= 1'b0;
              LCD_DB <= (column == 6'd16) ? 8'hC0 : 8'h80;
            end
`endif
          end
        end
        SETUP: cnt <= 20'(EPW_CYC);
        EHIGH: cnt <= cnt - 20'd1;
        HOLD:  cnt <= (!LCD_RS && LCD_DB == 8'h01) ? 20'(CLR_CYC) : 20'(CMD_CYC);
        WAIT: begin
          cnt <= cnt - 20'd1;
          if (cnt_done && op == OP_INIT) init_idx <= init_idx + 3'd1;
        end
        DONE: begin
          if (op == OP_CHAR) begin
            write_done <= 1'b1;
            column     <= (column == 6'd31) ? 6'd0 : column + 6'd1;
`ifdef LCD_AUTOWRAP_EN
            if (column == 6'd31) wrapped <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_write_engine.sv
// tb/tb_lcd_write_engine.sv - self-checking bench for lcd_write_engine (LCD_AUTOWRAP_EN optional)
module tb_lcd_write_engine;
  localparam int PWRUP_CYC = 20;
  localparam int EPW_CYC   = 2;
  localparam int CMD_CYC   = 4;
  localparam int CLR_CYC   = 10;
  localparam int XFER_CLK  = EPW_CYC + CMD_CYC + 3;
  localparam int CLR_BUSY  = 1 + EPW_CYC + 1 + CLR_CYC + 1;
`ifdef LCD_AUTOWRAP_EN
  localparam bit AUTOWRAP = 1'b1;
`else
  localparam bit AUTOWRAP = 1'b0;
`endif

  typedef struct { logic rs; logic [7:0] db; int width; bit stable; } xfer_t;
  typedef struct { bit ws; bit clr; logic [7:0] d; int hold; int exp_lo; int exp_lat; int exp_wd; int exp_word; } vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db;
  int         n_checks = 0;
  int         n_fail   = 0;
  xfer_t      bus_q[$];
  xfer_t      cur;
  logic       e_prev = 1'b0;
  int         rw_bad = 0;
  int         exp_q[$];
  int         chars = 0;
  vec_t       vecs[7];

  lcd_write_engine_if host();

  lcd_write_engine #(
    .PWRUP_CYC(PWRUP_CYC), .EPW_CYC(EPW_CYC), .CMD_CYC(CMD_CYC), .CLR_CYC(CLR_CYC)
  ) dut (
    .clkLCD(clk), .resetLCD_n(rst_n), .host(host),
    .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_E(lcd_e), .LCD_DB(lcd_db)
  );

  always #5 clk = ~clk;

  // Bus monitor: one record per E pulse, with its width and bus stability.
  always @(negedge clk) begin
    if (lcd_rw !== 1'b0) rw_bad++;
    if (lcd_e === 1'b1) begin
      if (!e_prev) begin
        cur.rs = lcd_rs; cur.db = lcd_db; cur.width = 1; cur.stable = 1'b1;
      end else begin
        cur.width++;
        if (lcd_db !== cur.db || lcd_rs !== cur.rs) cur.stable = 1'b0;
      end
    end else if (e_prev) begin
      bus_q.push_back(cur);
    end
    e_prev = lcd_e;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic compare_bus(input string name);
    check({name, " xfer count"}, bus_q.size(), exp_q.size());
    for (int i = 0; i < bus_q.size() && i < exp_q.size(); i++) begin
      check({name, " xfer rs/db"}, {23'd0, bus_q[i].rs, bus_q[i].db}, exp_q[i]);
      check({name, " E width"}, bus_q[i].width, EPW_CYC);
      check({name, " bus stable in E"}, int'(bus_q[i].stable), 1);
    end
  endtask

  function automatic bit need_addr(input int n);
    return AUTOWRAP && ((n % 32 == 16) || (n % 32 == 0 && n > 0));
  endfunction

  task automatic run_op(input string name, input bit ws, input bit clr, input logic [7:0] d,
                        input int clr_hold, input int exp_lo, input int exp_lat, input int exp_wd);
    int lo, lat, wd, n;
    lo = 0; lat = -1; wd = 0;
    n = ((clr_hold > exp_lo) ? clr_hold : exp_lo) + 8;
    @(negedge clk);
    check({name, " ready before"}, int'(host.initDone), 1);
    host.writeStart = ws; host.data = d; host.clrLCD = clr;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      host.writeStart = 1'b0;
      if (k >= clr_hold) host.clrLCD = 1'b0;
      if (!host.initDone) lo++;
      if (host.writeDone) begin
        wd++;
        if (lat < 0) lat = k - 1;
      end
    end
    check({name, " initDone low clocks"}, lo, exp_lo);
    check({name, " writeDone latency"}, lat, exp_lat);
    check({name, " writeDone count"}, wd, exp_wd);
  endtask

  task automatic model_write(input string name, input logic [7:0] d);
    int a;
    a = int'(need_addr(chars));
    exp_q.delete();
    if (a != 0) exp_q.push_back((chars % 32 == 16) ? 'h0C0 : 'h080);
    exp_q.push_back('h100 | int'(d));
    bus_q.delete();
    run_op(name, 1'b1, 1'b0, d, 0, XFER_CLK * (1 + a), XFER_CLK * (1 + a), 1);
    compare_bus(name);
    chars++;
  endtask

  task automatic model_clear(input string name, input int hold);
    exp_q.delete();
    exp_q.push_back('h001);
    bus_q.delete();
    run_op(name, 1'b0, 1'b1, 8'h00, hold, CLR_BUSY, -1, 0);
    compare_bus(name);
    chars = 0;
  endtask

  task automatic do_init(input string name);
    int wd;
    bit done;
    wd = 0; done = 1'b0;
    rst_n = 1'b0;
    host.writeStart = 1'b0; host.clrLCD = 1'b0; host.data = 8'h00;
    repeat (3) @(negedge clk);
    check({name, " reset E"}, int'(lcd_e), 0);
    check({name, " reset RS"}, int'(lcd_rs), 0);
    check({name, " reset DB"}, int'(lcd_db), 0);
    check({name, " reset initDone"}, int'(host.initDone), 0);
    check({name, " reset writeDone"}, int'(host.writeDone), 0);
    bus_q.delete();
    rst_n = 1'b1;
    for (int k = 1; k <= 400 && !done; k++) begin
      @(negedge clk);
      host.writeStart = (k == 5);
      host.data = 8'h99;
      if (host.writeDone) wd++;
      if (host.initDone) done = 1'b1;
    end
    host.writeStart = 1'b0;
    check({name, " initDone reached"}, int'(done), 1);
    check({name, " no writeDone in init"}, wd, 0);
    exp_q.delete();
    exp_q.push_back('h038); exp_q.push_back('h038); exp_q.push_back('h038);
    exp_q.push_back('h00C); exp_q.push_back('h001); exp_q.push_back('h006);
    compare_bus(name);
    chars = 0;
  endtask

  initial begin
    int n_pre, wd, lo;
    bit found;
    vecs[0] = '{ws:1, clr:0, d:8'h41, hold:0, exp_lo:XFER_CLK, exp_lat:XFER_CLK, exp_wd:1, exp_word:'h141};
    vecs[1] = '{ws:1, clr:0, d:8'h7A, hold:0, exp_lo:XFER_CLK, exp_lat:XFER_CLK, exp_wd:1, exp_word:'h17A};
    vecs[2] = '{ws:0, clr:1, d:8'h00, hold:30, exp_lo:CLR_BUSY, exp_lat:-1, exp_wd:0, exp_word:'h001};
    vecs[3] = '{ws:1, clr:1, d:8'h55, hold:1, exp_lo:CLR_BUSY, exp_lat:-1, exp_wd:0, exp_word:'h001};
    vecs[4] = '{ws:1, clr:0, d:8'h01, hold:0, exp_lo:XFER_CLK, exp_lat:XFER_CLK, exp_wd:1, exp_word:'h101};
    vecs[5] = '{ws:0, clr:1, d:8'h00, hold:1, exp_lo:CLR_BUSY, exp_lat:-1, exp_wd:0, exp_word:'h001};
    vecs[6] = '{ws:1, clr:0, d:8'h20, hold:0, exp_lo:XFER_CLK, exp_lat:XFER_CLK, exp_wd:1, exp_word:'h120};

    do_init("init");

    for (int i = 0; i < 7; i++) begin
      exp_q.delete();
      exp_q.push_back(vecs[i].exp_word);
      bus_q.delete();
      run_op($sformatf("vec%0d", i), vecs[i].ws, vecs[i].clr, vecs[i].d, vecs[i].hold,
             vecs[i].exp_lo, vecs[i].exp_lat, vecs[i].exp_wd);
      compare_bus($sformatf("vec%0d", i));
      if (vecs[i].clr) chars = 0;
      else             chars++;
    end

    // writeStart and a clrLCD pulse arriving while busy are both discarded.
    exp_q.delete(); exp_q.push_back('h142);
    bus_q.delete();
    lo = 0; wd = 0;
    @(negedge clk);
    host.writeStart = 1'b1; host.data = 8'h42;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      host.writeStart = 1'b0;
      if (k == 3) begin host.writeStart = 1'b1; host.data = 8'h55; host.clrLCD = 1'b1; end
      if (k == 5) host.clrLCD = 1'b0;
      if (!host.initDone) lo++;
      if (host.writeDone) wd++;
    end
    check("busy ignore initDone low", lo, XFER_CLK);
    check("busy ignore writeDone count", wd, 1);
    compare_bus("busy ignore");
    chars++;

    for (int i = 0; i < 45; i++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r == 0) model_clear("rnd clr", $urandom_range(1, 20));
      else        model_write("rnd wr", 8'($urandom_range(32, 126)));
    end

    // 17 characters from a fresh init, reset during the last character's E pulse.
    do_init("init2");
    for (int i = 0; i < 16; i++) model_write("fill", 8'h30);
    exp_q.delete();
    if (need_addr(chars)) exp_q.push_back((chars % 32 == 16) ? 'h0C0 : 'h080);
    n_pre = exp_q.size();
    bus_q.delete();
    wd = 0; found = 1'b0;
    @(negedge clk);
    host.writeStart = 1'b1; host.data = 8'h30;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      host.writeStart = 1'b0;
      if (host.writeDone) wd++;
      if (lcd_e && bus_q.size() == n_pre) found = 1'b1;
    end
    check("w17 char E seen", int'(found), 1);
    check("w17 char rs/db", {23'd0, lcd_rs, lcd_db}, 'h130);
    check("w17 no early writeDone", wd, 0);
    compare_bus("w17 pre");
    rst_n = 1'b0;
    #1;
    check("abort E", int'(lcd_e), 0);
    check("abort initDone", int'(host.initDone), 0);
    check("abort writeDone", int'(host.writeDone), 0);
    check("abort DB", int'(lcd_db), 0);
    do_init("reinit");
    model_write("post reinit", 8'h41);

    check("RW always 0", rw_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
